fp_cla_adder: RTL and testbench

- Registered IEEE-754 floating-point adder/subtractor.
- Adds two operands of the same format with sign handling. Mantissa addition and subtraction use a carry-lookahead adder.
- Used as the FP add datapath block. The result is registered, so it can sit directly in a clocked pipeline.

---
 rtl/fp_cla_adder.sv | 181 ++++++++++++++++++
 tb/tb_fp_cla_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fp_cla_adder.sv
// -----------------------------------------------------------------------------
// fp_cla_adder
//
// Registered IEEE-754 single-precision adder. Operands are aligned, then
// added or subtracted with a 27-bit carry-lookahead adder (4-bit groups).
// The sum is normalised and rounded to nearest-even. The result is
// registered, so the latency is one cycle and a new pair is accepted on
// every cycle.
//
// Simplifications: denormal inputs are flushed to zero, and results that
// underflow become signed zero.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset, clears sum to +0
//   a    - operand A (IEEE-754 single)
//   b    - operand B (IEEE-754 single)
//   sum  - registered a + b
// -----------------------------------------------------------------------------
module fp_cla_adder #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // 27-bit carry-lookahead adder. Bits 0..23 form six full 4-bit groups;
  // group carries are resolved by lookahead, bits inside a group ripple
  // from their group carry-in. The top three bits form a short group.
  // The return value is {carry_out, sum[26:0]}.
  function automatic logic [27:0] cla27(input logic [26:0] x,
                                        input logic [26:0] y,
                                        input logic        cin);
    logic [26:0] g, p, c;
    logic [5:0]  gg, gp;
    logic [6:0]  gc;
    logic        cout;
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < 6; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    for (int k = 0; k < 6; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    c[0] = gc[0];
    for (int i = 1; i < 27; i++) begin
      c[i] = (i % 4 == 0) ? gc[i/4] : (g[i-1] | (p[i-1] & c[i-1]));
    end
    cout = g[26] | (p[26] & c[26]);
    return {cout, p ^ c};
  endfunction

  // Leading-zero count of a 27-bit value. An all-zero input returns 27.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               a_ge_b;
  logic               big_s, small_s, sub;
  logic [7:0]         big_e, small_e, exp_diff;
  logic [22:0]        big_f, small_f;
  logic [26:0]        big_x, small_x, small_al, addend, norm;
  logic               lost;
  logic [27:0]        raw;
  logic [4:0]         lz;
  logic               zero_res, round_up;
  logic [24:0]        mant_r;
  logic [22:0]        frac;
  logic signed [9:0]  exp_n, exp_r;
  logic [31:0]        result;

  // NOTE: every variable gets a default at the top of this block, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    a_zero   = (a[30:23] == 8'h00);
    b_zero   = (b[30:23] == 8'h00);
    a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf    = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    // Magnitude order is exponent first, then fraction. This is exactly
    // the unsigned order of the low 31 bits.
    a_ge_b   = (a[30:0] >= b[30:0]);
    big_s    = a_ge_b ? a[31]    : b[31];
    big_e    = a_ge_b ? a[30:23] : b[30:23];
    big_f    = a_ge_b ? a[22:0]  : b[22:0];
    small_s  = a_ge_b ? b[31]    : a[31];
    small_e  = a_ge_b ? b[30:23] : a[30:23];
    small_f  = a_ge_b ? b[22:0]  : a[22:0];
    sub      = big_s ^ small_s;
    exp_diff = big_e - small_e;

    // Mantissas carry three extra low bits: guard, round and sticky.
    big_x    = {1'b1, big_f, 3'b000};
    small_x  = {1'b1, small_f, 3'b000};
    small_al = 27'd1;
    lost     = 1'b0;
    if (exp_diff < 8'd26) begin
      small_al    = small_x >> exp_diff;
      lost        = |(small_x & ~({27{1'b1}} << exp_diff));
      small_al[0] = small_al[0] | lost;
    end

    // Subtraction is big + ~small + 1. The borrow-out is ignored because
    // big >= small in magnitude.
    addend   = sub ? ~small_al : small_al;
    raw      = cla27(big_x, addend, sub);

    lz       = lzc27(raw[26:0]);
    zero_res = 1'b0;
    if (!sub && raw[27]) begin
      norm  = {1'b1, raw[26:2], raw[1] | raw[0]};
      exp_n = $signed({2'b00, big_e}) + 10'sd1;
    end else begin
      zero_res = (raw[26:0] == 27'h0);
      norm     = raw[26:0] << lz;
      exp_n    = $signed({2'b00, big_e}) - $signed({5'b00000, lz});
    end

    // Round to nearest, ties to even, on norm[3]. A carry into bit 24
    // means the mantissa rounded up to 2.0, so bump the exponent.
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[26:3]} + {24'h0, round_up};
    exp_r    = exp_n + $signed({9'h000, mant_r[24]});
    frac     = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      result = QNAN;
    end else if (a_inf) begin
      result = a;
    end else if (b_inf) begin
      result = b;
    end else if (a_zero && b_zero) begin
      result = 32'h0;
    end else if (a_zero) begin
      result = b;
    end else if (b_zero) begin
      result = a;
    end else if (zero_res) begin
      result = 32'h0;
    end else if (exp_n <= 10'sd0) begin
      result = {big_s, 31'h0};
    end else if (exp_r >= 10'sd255) begin
      result = {big_s, 8'hFF, 23'h0};
    end else begin
      result = {big_s, exp_r[7:0], frac};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input before any flop updates in the same edge.
  // NOTE: the output register is reset asynchronously, so sum reads +0 as
  // soon as rst rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum <= '0;
    else     sum <= result;
  end

endmodule

// File: tb/tb_fp_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_fp_cla_adder
//
// Self-checking bench for fp_cla_adder. The reference model does exact
// arithmetic on wide integers, then applies IEEE round-to-nearest-even
// and the block's special-case rules. One compare process checks sum
// against the model's one-cycle-delayed result on every falling edge.
// Directed vectors are also checked against hand-computed literals, and
// those literals also pin the model itself.
// -----------------------------------------------------------------------------
module tb_fp_cla_adder;

  logic        clk;
  logic        rst;
  logic [31:0] a, b, sum;

  int tests = 0;
  int fails = 0;
  logic        chk_en = 1'b0;
  logic [31:0] exp_q;

  fp_cla_adder #(.W(32)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .sum (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NV = 20;
  localparam logic [31:0] VA [NV] = '{
    32'h404CCCCC, 32'h3F28F5C2, 32'hBF000000, 32'hBF000000, 32'h4034B4B5,
    32'h3F800000, 32'h41200000, 32'h3FC00000, 32'h7F7FFFFF, 32'h7F800000,
    32'h00000000, 32'h7F800001, 32'hFF800000, 32'h00800000, 32'h80000000,
    32'h00000001, 32'h3F800000, 32'h3F800001, 32'h3F800000, 32'h7F7FFFFF};
  localparam logic [31:0] VB [NV] = '{
    32'h40866666, 32'h3F028F5C, 32'hC0CCCCCC, 32'h40CCCCCC, 32'hBF70F0F1,
    32'hBF800000, 32'hC1200000, 32'h3FC00000, 32'h7F7FFFFF, 32'hFF800000,
    32'hC1200000, 32'h3F800000, 32'h3F800000, 32'h80800001, 32'h80000000,
    32'h3F800000, 32'h33800000, 32'h33800000, 32'hB3000000, 32'h73000000};
  localparam logic [31:0] VE [NV] = '{
    32'h40ECCCCC, 32'h3F95C28F, 32'hC0DCCCCC, 32'h40BCCCCC, 32'h3FF0F0F1,
    32'h00000000, 32'h00000000, 32'h40400000, 32'h7F800000, 32'h7FC00000,
    32'hC1200000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000000,
    32'h3F800000, 32'h3F800000, 32'h3F800002, 32'h3F800000, 32'h7F800000};
  localparam int VT [NV] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0,
                             0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  // Reference: each operand is an exact integer M * 2^(E-150). The two are
  // summed exactly on a common scale, then rounded once.
  function automatic logic [31:0] fp_model(input logic [31:0] x, input logic [31:0] y);
    int           ex, ey, emin, p, e, k;
    logic [299:0] mx, my, mag, q, rem, half;
    logic         sx, sy, s, up;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sx = x[31];
    sy = y[31];
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return 32'h7FC00000;
    if (ex == 255 && ey == 255) return (sx == sy) ? x : 32'h7FC00000;
    if (ex == 255) return x;
    if (ey == 255) return y;
    mx = (ex == 0) ? 300'h0 : {276'h0, 1'b1, x[22:0]};
    my = (ey == 0) ? 300'h0 : {276'h0, 1'b1, y[22:0]};
    if (ex == 0) ex = 1;
    if (ey == 0) ey = 1;
    emin = (ex < ey) ? ex : ey;
    mx = mx << (ex - emin);
    my = my << (ey - emin);
    if (sx == sy) begin
      mag = mx + my; s = sx;
    end else if (mx >= my) begin
      mag = mx - my; s = sx;
    end else begin
      mag = my - mx; s = sy;
    end
    if (mag == 0) return 32'h00000000;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p + emin - 23;
    if (e <= 0) return {s, 31'h0};
    if (p > 23) begin
      k    = p - 23;
      q    = mag >> k;
      rem  = mag & ((300'h1 << k) - 300'h1);
      half = 300'h1 << (k - 1);
      up   = (rem > half) || (rem == half && q[0]);
      q    = q + {299'h0, up};
      if (q[24]) begin
        q = q >> 1;
        e = e + 1;
      end
    end else begin
      q = mag << (23 - p);
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h", name, act, req);
    end
  endtask

  // Same-sign values within tol units in the last place pass.
  task automatic check_ulp(input string name, input logic [31:0] act,
                           input logic [31:0] req, input int tol);
    int d;
    tests++;
    d = int'(act[30:0]) - int'(req[30:0]);
    if (d < 0) d = -d;
    if ((^act === 1'bx) || act[31] != req[31] || d > tol) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h (+/-%0d ulp)", name, act, req, tol);
    end
  endtask

  // One-cycle latency stage in front of the model result.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q <= 32'h0;
    else     exp_q <= fp_model(a, b);
  end

  always @(negedge clk) begin
    if (chk_en) check("pipe", sum, exp_q);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a   = 32'h3F800000;
    b   = 32'h40000000;
    #1 check("reset_initial", sum, 32'h0);
    repeat (2) @(negedge clk);
    check("reset_hold", sum, 32'h0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Pin the model against hand-computed results.
    for (int i = 0; i < NV; i++) begin
      check_ulp($sformatf("model%0d", i), fp_model(VA[i], VB[i]), VE[i], VT[i]);
    end

    // Directed vectors applied back to back, one per cycle.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a = VA[i];
      b = VB[i];
      @(posedge clk);
      #1 check_ulp($sformatf("vec%0d", i), sum, VE[i], VT[i]);
    end

    // The same vectors with the operands swapped must give the same result.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a = VB[i];
      b = VA[i];
      @(posedge clk);
      #1 check_ulp($sformatf("swap%0d", i), sum, VE[i], VT[i]);
    end

    // Assert reset in the middle of an operation.
    @(negedge clk);
    a = 32'h404CCCCC;
    b = 32'h40866666;
    @(posedge clk);
    #1 check("pre_reset", sum, 32'h40ECCCCC);
    a = 32'h3FC00000;
    b = 32'h3FC00000;
    #2 rst = 1'b1;
    #1 check("reset_async", sum, 32'h0);
    @(posedge clk);
    #1 check("reset_held", sum, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("reset_release", sum, 32'h40400000);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
